// File: rtl/dual_lane_data_mem.sv
// Two-lane byte-addressed data memory. Lane A is older than lane B. Loads return
// sign- or zero-extended data one cycle after the request, from a registered output.
module dual_lane_data_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ReqA,
  input  logic                  WeA,
  input  logic [2:0]            SizeA,
  input  logic [DATA_WIDTH-1:0] AddrA,
  input  logic [DATA_WIDTH-1:0] WdataA,
  output logic [DATA_WIDTH-1:0] RdataA,
  output logic                  RvalidA,
  output logic                  ErrA,
  input  logic                  ReqB,
  input  logic                  WeB,
  input  logic [2:0]            SizeB,
  input  logic [DATA_WIDTH-1:0] AddrB,
  input  logic [DATA_WIDTH-1:0] WdataB,
  output logic [DATA_WIDTH-1:0] RdataB,
  output logic                  RvalidB,
  output logic                  ErrB
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] maddr_t;
  typedef logic [7:0]            byte_t;

  typedef struct packed {
    logic       legal;
    logic [2:0] nbytes;
  } access_t;

  // Legality covers both the funct3 code for this access type and alignment.
  function automatic access_t decode(input logic we, input logic [2:0] size,
                                     input logic [1:0] lsb);
    access_t d;
    d = '0;
    case (size)
      3'b000: begin d.legal = 1'b1;                  d.nbytes = 3'd1; end
      3'b001: begin d.legal = ~lsb[0];               d.nbytes = 3'd2; end
      3'b010: begin d.legal = (lsb == 2'b00);        d.nbytes = 3'd4; end
      3'b100: begin d.legal = ~we;                   d.nbytes = 3'd1; end
      3'b101: begin d.legal = ~we & ~lsb[0];         d.nbytes = 3'd2; end
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] size,
                                         input byte_t b0, b1, b2, b3);
    case (size)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b100:  return {24'h0, b0};
      3'b101:  return {16'h0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  byte_t   mem [DEPTH];

  maddr_t  addr_a, addr_b;
  access_t dec_a, dec_b;
  logic    ok_a, ok_b, st_a, st_b, ld_a, ld_b;
  byte_t   rd_a [4];
  byte_t   rd_b [4];
  maddr_t  fwd_off [4];
  logic [DATA_WIDTH-1:0] load_a, load_b;

  // Address bits above the decoded range are ignored so accesses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{AddrA[DATA_WIDTH-1:ADDR_WIDTH], AddrB[DATA_WIDTH-1:ADDR_WIDTH]};

  assign addr_a = AddrA[ADDR_WIDTH-1:0];
  assign addr_b = AddrB[ADDR_WIDTH-1:0];
  assign dec_a  = decode(WeA, SizeA, AddrA[1:0]);
  assign dec_b  = decode(WeB, SizeB, AddrB[1:0]);
  assign ok_a   = ReqA & dec_a.legal;
  assign ok_b   = ReqB & dec_b.legal;
  assign st_a   = ok_a & WeA;
  assign st_b   = ok_b & WeB;
  assign ld_a   = ok_a & ~WeA;
  assign ld_b   = ok_b & ~WeB;

  // Lane B sees lane A's same-cycle store byte by byte; lane A never sees lane B's.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      // NOTE: every combinational output gets a default before any conditional override, so no latch is inferred.
      rd_a[i]    = mem[addr_a + maddr_t'(i)];
      rd_b[i]    = mem[addr_b + maddr_t'(i)];
      fwd_off[i] = addr_b + maddr_t'(i) - addr_a;
      if (st_a && (fwd_off[i] < maddr_t'(dec_a.nbytes)))
        rd_b[i] = WdataA[8*fwd_off[i][1:0] +: 8];
    end
  end

  assign load_a = ld_a ? extend(SizeA, rd_a[0], rd_a[1], rd_a[2], rd_a[3]) : '0;
  assign load_b = ld_b ? extend(SizeB, rd_b[0], rd_b[1], rd_b[2], rd_b[3]) : '0;

  // NOTE: the byte array has no reset; clearing it would defeat RAM inference and contents must survive reset anyway.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: non-blocking writes resolve last-wins, so lane B's bytes overwrite lane A's on overlap.
      for (int i = 0; i < 4; i++)
        if (st_a && (i < int'(dec_a.nbytes)))
          mem[addr_a + maddr_t'(i)] <= WdataA[8*i +: 8];
      for (int i = 0; i < 4; i++)
        if (st_b && (i < int'(dec_b.nbytes)))
          mem[addr_b + maddr_t'(i)] <= WdataB[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RdataA  <= '0;
      RvalidA <= 1'b0;
      ErrA    <= 1'b0;
      RdataB  <= '0;
      RvalidB <= 1'b0;
      ErrB    <= 1'b0;
    end else begin
      RdataA  <= load_a;
      RvalidA <= ReqA;
      ErrA    <= ReqA & ~dec_a.legal;
      RdataB  <= load_b;
      RvalidB <= ReqB;
      ErrB    <= ReqB & ~dec_b.legal;
    end
  end

endmodule

// File: tb/tb_dual_lane_data_mem.sv
// Bench for dual_lane_data_mem: a sequential byte-map model (lane A applied, then lane B)
// predicts every response; directed cases pin both the model and the DUT to literal values.
module tb_dual_lane_data_mem;

  localparam int AW = 17;
  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd4, LHU = 3'd5;
  localparam logic [2:0] SB = 3'd0, SH = 3'd1, SW = 3'd2;

  typedef struct {
    bit          req;
    bit          we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lane_t;

  typedef struct {
    logic [31:0] rdata;
    logic        valid;
    logic        err;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ReqA, WeA, ReqB, WeB;
  logic [2:0]  SizeA, SizeB;
  logic [31:0] AddrA, WdataA, AddrB, WdataB;
  logic [31:0] RdataA, RdataB;
  logic        RvalidA, ErrA, RvalidB, ErrB;

  int    n_checks = 0;
  int    n_errors = 0;
  bit    cmp_en   = 1'b0;
  resp_t exp_a, exp_b;
  logic [7:0] mm [int];

  always #5 clk = ~clk;

  dual_lane_data_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .ReqA(ReqA), .WeA(WeA), .SizeA(SizeA), .AddrA(AddrA), .WdataA(WdataA),
    .RdataA(RdataA), .RvalidA(RvalidA), .ErrA(ErrA),
    .ReqB(ReqB), .WeB(WeB), .SizeB(SizeB), .AddrB(AddrB), .WdataB(WdataB),
    .RdataB(RdataB), .RvalidB(RvalidB), .ErrB(ErrB)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic resp_t no_resp();
    resp_t r;
    r.rdata = '0; r.valid = 1'b0; r.err = 1'b0;
    return r;
  endfunction

  function automatic lane_t idle();
    lane_t l;
    l.req = 1'b0; l.we = 1'b0; l.size = '0; l.addr = '0; l.wdata = '0;
    return l;
  endfunction

  function automatic lane_t ld(input logic [2:0] sz, input logic [31:0] ad);
    lane_t l;
    l.req = 1'b1; l.we = 1'b0; l.size = sz; l.addr = ad; l.wdata = $urandom;
    return l;
  endfunction

  function automatic lane_t st(input logic [2:0] sz, input logic [31:0] ad, input logic [31:0] d);
    lane_t l;
    l.req = 1'b1; l.we = 1'b1; l.size = sz; l.addr = ad; l.wdata = d;
    return l;
  endfunction

  function automatic lane_t rand_lane();
    lane_t l;
    l.req   = ($urandom_range(0, 3) != 0);
    l.we    = 1'($urandom_range(0, 1));
    l.size  = 3'($urandom_range(0, 7));
    l.addr  = (32'h400 + 32'($urandom_range(0, 31))) | ($urandom << AW);
    l.wdata = $urandom;
    return l;
  endfunction

  function automatic bit legal(input lane_t l);
    case (l.size)
      3'd0:    return 1'b1;
      3'd1:    return !l.addr[0];
      3'd2:    return l.addr[1:0] == 2'b00;
      3'd4:    return !l.we;
      3'd5:    return !l.we && !l.addr[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic int mkey(input logic [31:0] a, input int i);
    logic [31:0] s;
    s = a + 32'(i);
    return int'(s % (32'd1 << AW));
  endfunction

  function automatic logic [7:0] mread(input int k);
    return mm.exists(k) ? mm[k] : 8'h00;
  endfunction

  // One lane's access against the byte map: stores update it, loads assemble bytes arithmetically.
  task automatic apply(input lane_t l, output resp_t r);
    int     n;
    longint v;
    r.rdata = '0;
    r.valid = l.req;
    r.err   = l.req && !legal(l);
    if (!l.req || r.err) return;
    n = 1 << l.size[1:0];
    if (l.we) begin
      for (int i = 0; i < n; i++)
        mm[mkey(l.addr, i)] = 8'((l.wdata >> (8 * i)) & 32'hFF);
    end else begin
      v = 0;
      for (int i = 0; i < n; i++)
        v += longint'(mread(mkey(l.addr, i))) << (8 * i);
      if (!l.size[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
        v -= longint'(1) << (8 * n);
      r.rdata = 32'(v);
    end
  endtask

  // One request cycle: drive after the falling edge, predict, then publish expectations after the rising edge.
  task automatic step(input lane_t a, input lane_t b, input bit r = 1'b0);
    resp_t ra, rb;
    @(negedge clk);
    #1;
    rst    = r;
    ReqA   = a.req; WeA = a.we; SizeA = a.size; AddrA = a.addr; WdataA = a.wdata;
    ReqB   = b.req; WeB = b.we; SizeB = b.size; AddrB = b.addr; WdataB = b.wdata;
    if (r) begin
      ra = no_resp();
      rb = no_resp();
    end else begin
      apply(a, ra);
      apply(b, rb);
    end
    @(posedge clk);
    #1;
    exp_a = ra;
    exp_b = rb;
  endtask

  task automatic lit(input string name, input bit lane_b, input logic [31:0] data, input bit err);
    resp_t m;
    m = lane_b ? exp_b : exp_a;
    check({name, "_model"}, m.rdata, data);
    check({name, "_rdata"}, lane_b ? RdataB : RdataA, data);
    check({name, "_rvalid"}, 32'(lane_b ? RvalidB : RvalidA), 32'd1);
    check({name, "_err"}, 32'(lane_b ? ErrB : ErrA), 32'(err));
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_rdata_a", RdataA, exp_a.rdata);
      check("cmp_rvalid_a", 32'(RvalidA), 32'(exp_a.valid));
      check("cmp_err_a", 32'(ErrA), 32'(exp_a.err));
      check("cmp_rdata_b", RdataB, exp_b.rdata);
      check("cmp_rvalid_b", 32'(RvalidB), 32'(exp_b.valid));
      check("cmp_err_b", 32'(ErrB), 32'(exp_b.err));
    end
  end

  initial begin
    rst  = 1'b1;
    ReqA = 1'b0; WeA = 1'b0; SizeA = '0; AddrA = '0; WdataA = '0;
    ReqB = 1'b0; WeB = 1'b0; SizeB = '0; AddrB = '0; WdataB = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata_a", RdataA, 32'h0);
    check("reset_rvalid_a", 32'(RvalidA), 32'h0);
    check("reset_err_a", 32'(ErrA), 32'h0);
    check("reset_rdata_b", RdataB, 32'h0);
    check("reset_rvalid_b", 32'(RvalidB), 32'h0);
    check("reset_err_b", 32'(ErrB), 32'h0);
    exp_a  = no_resp();
    exp_b  = no_resp();
    cmp_en = 1'b1;

    step(st(SW, 32'h100, 32'hDEADBEEF), idle());
    lit("sw_resp", 0, 32'h0, 0);
    step(ld(LW, 32'h100), idle());
    lit("sw_lw", 0, 32'hDEADBEEF, 0);
    step(ld(LB, 32'h103), ld(LBU, 32'h103));
    lit("lb", 0, 32'hFFFFFFDE, 0);
    lit("lbu", 1, 32'h000000DE, 0);
    step(ld(LH, 32'h102), ld(LHU, 32'h100));
    lit("lh", 0, 32'hFFFFDEAD, 0);
    lit("lhu", 1, 32'h0000BEEF, 0);
    step(st(SB, 32'h101, 32'h55), idle());
    step(ld(LW, 32'h100), idle());
    lit("sb_lw", 0, 32'hDEAD55EF, 0);

    step(st(SW, 32'h200, 32'h11223344), idle());
    step(st(SH, 32'h200, 32'hAAAA), ld(LW, 32'h200));
    lit("fwd_a_to_b", 1, 32'h1122AAAA, 0);
    step(st(SW, 32'h200, 32'h11223344), idle());
    step(ld(LW, 32'h200), st(SH, 32'h200, 32'hAAAA));
    lit("a_sees_old", 0, 32'h11223344, 0);
    step(ld(LW, 32'h200), idle());
    lit("b_store_lands", 0, 32'h1122AAAA, 0);

    step(st(SW, 32'h300, 32'h11111111), st(SB, 32'h300, 32'h22));
    step(ld(LW, 32'h300), idle());
    lit("collision", 0, 32'h11111122, 0);
    step(ld(LW, 32'h102), idle());
    lit("lw_misalign", 0, 32'h0, 1);
    step(idle(), st(SH, 32'h301, 32'hFFFF));
    lit("sh_misalign", 1, 32'h0, 1);
    step(st(3'b011, 32'h300, 32'hFFFFFFFF), ld(LW, 32'h300));
    lit("bad_size_store", 0, 32'h0, 1);
    lit("err_no_fwd", 1, 32'h11111122, 0);
    step(ld(LW, 32'h300), idle());
    lit("mem_unchanged", 0, 32'h11111122, 0);

    step(st(SW, 32'h00020100, 32'hCAFEF00D), idle());
    step(ld(LW, 32'h100), ld(LW, 32'h100));
    lit("wrap_a", 0, 32'hCAFEF00D, 0);
    lit("wrap_b", 1, 32'hCAFEF00D, 0);

    step(ld(LW, 32'h100), idle(), 1'b1);
    check("drop_rvalid_a", 32'(RvalidA), 32'h0);
    check("drop_rdata_a", RdataA, 32'h0);
    check("drop_err_a", 32'(ErrA), 32'h0);
    step(idle(), idle());
    check("drop_later_rvalid_a", 32'(RvalidA), 32'h0);

    for (int i = 0; i < 8; i++)
      step(st(SW, 32'h400 + 32'(4 * i), $urandom), idle());
    for (int c = 0; c < 3000; c++)
      step(rand_lane(), rand_lane(), ($urandom_range(0, 199) == 0));
    step(idle(), idle());
    step(idle(), idle());
    @(negedge clk);
    #1;
    cmp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
